// File: rtl/sig_playback_pkg.sv
// Shared types and sizes for the signal playback engine.
// The word format and FSM encoding live here so sigStorage-side code can share them.
package sig_playback_pkg;

    localparam int unsigned MEM_W         = 32;
    localparam int unsigned PLAY_COUNT_W  = 30;
    localparam int unsigned PLAY_WCNT_W   = 16;
    localparam int unsigned FETCH_LATENCY = 3;
    localparam int unsigned FETCH_W       = $clog2(FETCH_LATENCY + 1);
    localparam logic        IDLE_LEVEL    = 1'b1;

    typedef logic [MEM_W-1:0] mem_t;

    typedef struct packed {
        logic                    level;
        logic                    last;
        logic [PLAY_COUNT_W-1:0] count;
    } playword_t;

    typedef enum logic [2:0] {
        s_idle,
        s_prime,
        s_hold,
        s_stall,
        s_done
    } playback_state_t;

    function automatic playword_t to_playword(input mem_t m);
        return playword_t'(m);
    endfunction

endpackage

// File: rtl/sig_playback_if.sv
// Control/data bundle between sigStorage, the channel unit and sig_playback.
// SIG_PLAYBACK_LOOP_EN adds the loopEn/rewind pair.
interface sig_playback_if;
    import sig_playback_pkg::*;

    logic                   start;
    logic                   abort;
    mem_t                   playbackIn;
    logic                   incrementAddr;
    logic                   txOut;
    logic                   busy;
    logic                   done;
    logic                   underrun;
    logic [PLAY_WCNT_W-1:0] wordCountDBG;
`ifdef SIG_PLAYBACK_LOOP_EN
    logic                   loopEn;
    logic                   rewind;
`endif

    modport master (
`ifdef SIG_PLAYBACK_LOOP_EN
        output loopEn,
        input  rewind,
`endif
        output start, abort, playbackIn,
        input  incrementAddr, txOut, busy, done, underrun, wordCountDBG
    );

    modport slave (
`ifdef SIG_PLAYBACK_LOOP_EN
        input  loopEn,
        output rewind,
`endif
        input  start, abort, playbackIn,
        output incrementAddr, txOut, busy, done, underrun, wordCountDBG
    );

endinterface

// File: rtl/sig_playback_oneshot.sv
// Registered rising-edge detector: one-clock pulse per 0->1 transition of in_i.
module sig_playback_oneshot (
    input  logic clk,
    input  logic resetN,
    input  logic in_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= in_i;
            pulse_q <= in_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/sig_playback.sv
// Replays timed bus levels from sigStorage words onto the channel TX pin,
// prefetching the next word while the current level is held. Loop mode: SIG_PLAYBACK_LOOP_EN.
module sig_playback
    import sig_playback_pkg::*;
(
    input  logic          clk,
    input  logic          resetN,
    sig_playback_if.slave bus
);

    playback_state_t         state_q, state_d;
    logic [PLAY_COUNT_W-1:0] hold_q, hold_d;
    logic [FETCH_W-1:0]      fetch_q, fetch_d, fetch_dec;
    logic                    last_q, last_d;
    logic                    tx_q, tx_d;
    logic                    inc_q, inc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    underrun_q, underrun_d;
    logic [PLAY_WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic                    start_pulse;
    logic                    take_word;
    playword_t               word;
`ifdef SIG_PLAYBACK_LOOP_EN
    logic                    rewind_q, rewind_d;
`endif

    sig_playback_oneshot u_start_edge (
        .clk     (clk),
        .resetN  (resetN),
        .in_i    (bus.start),
        .pulse_o (start_pulse)
    );

    assign word      = to_playword(bus.playbackIn);
    assign fetch_dec = (fetch_q == '0) ? '0 : fetch_q - FETCH_W'(1);

    // fetch_dec==0 means the prefetched word is valid at this clock edge
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        fetch_d    = fetch_dec;
        last_d     = last_q;
        tx_d       = tx_q;
        inc_d      = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        wcnt_d     = wcnt_q;
        take_word  = 1'b0;
`ifdef SIG_PLAYBACK_LOOP_EN
        rewind_d   = 1'b0;
`endif

        unique case (state_q)
            s_idle: begin
                tx_d = IDLE_LEVEL;
                if (start_pulse) begin
                    underrun_d = 1'b0;
                    wcnt_d     = '0;
                    fetch_d    = FETCH_W'(FETCH_LATENCY);
                    state_d    = s_prime;
                end
            end
            s_prime: begin
                if (fetch_dec == '0) take_word = 1'b1;
            end
            s_hold: begin
                hold_d = (hold_q == '0) ? '0 : hold_q - PLAY_COUNT_W'(1);
                if (hold_q == '0) begin
                    if (last_q) begin
`ifdef SIG_PLAYBACK_LOOP_EN
                        if (bus.loopEn) begin
                            rewind_d = 1'b1;
                            fetch_d  = FETCH_W'(FETCH_LATENCY);
                            state_d  = s_prime;
                        end else
`endif
                        begin
                            done_d  = 1'b1;
                            tx_d    = IDLE_LEVEL;
                            state_d = s_done;
                        end
                    end else if (fetch_dec == '0) begin
                        take_word = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = s_stall;
                    end
                end
            end
            s_stall: begin
                if (fetch_dec == '0) take_word = 1'b1;
            end
            s_done: begin
                tx_d    = IDLE_LEVEL;
                state_d = s_idle;
            end
            default: state_d = s_idle;
        endcase

        // Latch cycle shared by every entry into s_hold
        if (take_word) begin
            tx_d    = word.level;
            hold_d  = word.count;
            last_d  = word.last;
            wcnt_d  = (wcnt_q == '1) ? wcnt_q : wcnt_q + PLAY_WCNT_W'(1);
            state_d = s_hold;
            if (!word.last) begin
                inc_d   = 1'b1;
                fetch_d = FETCH_W'(FETCH_LATENCY);
            end
        end

        if (bus.abort) begin
            state_d = s_idle;
            tx_d    = IDLE_LEVEL;
            inc_d   = 1'b0;
            done_d  = 1'b0;
`ifdef SIG_PLAYBACK_LOOP_EN
            rewind_d = 1'b0;
`endif
        end

        busy_d = (state_d != s_idle);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= s_idle;
            hold_q     <= '0;
            fetch_q    <= '0;
            last_q     <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            inc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            wcnt_q     <= '0;
`ifdef SIG_PLAYBACK_LOOP_EN
            rewind_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            fetch_q    <= fetch_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            inc_q      <= inc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            wcnt_q     <= wcnt_d;
`ifdef SIG_PLAYBACK_LOOP_EN
            rewind_q   <= rewind_d;
`endif
        end
    end

    assign bus.incrementAddr = inc_q;
    assign bus.txOut         = tx_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.underrun      = underrun_q;
    assign bus.wordCountDBG  = wcnt_q;
`ifdef SIG_PLAYBACK_LOOP_EN
    assign bus.rewind        = rewind_q;
`endif

endmodule

// File: tb/tb_sig_playback.sv
// Directed bench for sig_playback with a small sigStorage pointer/RAM model.
// Loop-mode checks are built when SIG_PLAYBACK_LOOP_EN is defined.
module tb_sig_playback;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    logic ptr_clr = 1'b0;
    always #5 clk = ~clk;

    sig_playback_if bus ();

    sig_playback dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    // Storage model: playbackIn reflects a pointer bump FETCH_LATENCY clocks after incrementAddr rises
    logic [31:0] mem [8];
    logic [2:0]  ptr_q;
    logic        inc_d1;
    logic        rew;
`ifdef SIG_PLAYBACK_LOOP_EN
    assign rew = bus.rewind;
`else
    assign rew = 1'b0;
`endif

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ptr_q  <= 3'd0;
            inc_d1 <= 1'b0;
        end else if (ptr_clr) begin
            ptr_q  <= 3'd0;
            inc_d1 <= 1'b0;
        end else begin
            inc_d1 <= bus.incrementAddr;
            if (rew)         ptr_q <= 3'd0;
            else if (inc_d1) ptr_q <= ptr_q + 3'd1;
        end
    end

    assign bus.playbackIn = mem[ptr_q];

    int total = 0;
    int bad   = 0;
    int k, inc_cnt, done_cnt, busy_cnt, tx0_cnt, rew_cnt;
    logic [63:0] tx_tr, inc_tr, done_tr, busy_tr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic lv, input logic ls, input int unsigned c);
        return {lv, ls, 30'(c)};
    endfunction

    task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        for (int i = 0; i < 8; i++) mem[i] = 32'd0;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
    endtask

    task automatic clear_trace();
        k = 0; inc_cnt = 0; done_cnt = 0; busy_cnt = 0; tx0_cnt = 0; rew_cnt = 0;
        tx_tr = '0; inc_tr = '0; done_tr = '0; busy_tr = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (k < 64) begin
                tx_tr[k]   = bus.txOut;
                inc_tr[k]  = bus.incrementAddr;
                done_tr[k] = bus.done;
                busy_tr[k] = bus.busy;
            end
            inc_cnt  += int'(bus.incrementAddr);
            done_cnt += int'(bus.done);
            busy_cnt += int'(bus.busy);
            tx0_cnt  += int'(!bus.txOut);
            rew_cnt  += int'(rew);
            k++;
        end
    endtask

    task automatic do_reset();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic restart_ptr();
        ptr_clr = 1'b1;
        @(posedge clk);
        #1;
        ptr_clr = 1'b0;
    endtask

    task automatic start_pulse_run(input int n);
        clear_trace();
        bus.start = 1'b1;
        run(1);
        bus.start = 1'b0;
        run(n - 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
`ifdef SIG_PLAYBACK_LOOP_EN
        bus.loopEn = 1'b0;
`endif
        load(32'd0, 32'd0, 32'd0);
        #2 resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx",    64'(bus.txOut), 64'd1);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_done",  64'(bus.done), 64'd0);
        chk("rst_inc",   64'(bus.incrementAddr), 64'd0);
        chk("rst_undr",  64'(bus.underrun), 64'd0);
        chk("rst_wcnt",  64'(bus.wordCountDBG), 64'd0);
        resetN = 1'b1;

        // Three-word table: levels 1/0/1 for 6/3/1 clocks
        load(mk(1'b1, 1'b0, 5), mk(1'b0, 1'b0, 2), mk(1'b1, 1'b1, 0));
        do_reset();
        start_pulse_run(24);
        chk("t1_tx",   64'(tx_tr[23:0]),   64'hFFE3FF);
        chk("t1_inc",  64'(inc_tr[23:0]),  64'h000410);
        chk("t1_done", 64'(done_tr[23:0]), 64'h004000);
        chk("t1_busy", 64'(busy_tr[23:0]), 64'h007FFE);
        chk("t1_wcnt", 64'(bus.wordCountDBG), 64'd3);
        chk("t1_undr", 64'(bus.underrun), 64'd0);

        // count=0 word cannot cover the fetch latency: stall + underrun
        load(mk(1'b0, 1'b0, 0), mk(1'b1, 1'b1, 4), 32'd0);
        do_reset();
        start_pulse_run(16);
        chk("t2_tx",   64'(tx_tr[15:0]),   64'hFF8F);
        chk("t2_inc",  64'(inc_tr[15:0]),  64'h0010);
        chk("t2_done", 64'(done_tr[15:0]), 64'h1000);
        chk("t2_busy", 64'(busy_tr[15:0]), 64'h1FFE);
        chk("t2_undr", 64'(bus.underrun), 64'd1);
        chk("t2_wcnt", 64'(bus.wordCountDBG), 64'd2);

        // Abort during a long hold; new start also clears the sticky underrun
        load(mk(1'b0, 1'b0, 100), mk(1'b1, 1'b1, 0), 32'd0);
        restart_ptr();
        start_pulse_run(10);
        chk("t3_tx_hold", 64'(bus.txOut), 64'd0);
        chk("t3_undr_clr", 64'(bus.underrun), 64'd0);
        chk("t3_wcnt", 64'(bus.wordCountDBG), 64'd1);
        bus.abort = 1'b1;
        run(1);
        chk("t3_ab_tx",   64'(bus.txOut), 64'd1);
        chk("t3_ab_busy", 64'(bus.busy), 64'd0);
        chk("t3_ab_done", 64'(bus.done), 64'd0);
        bus.abort = 1'b0;
        clear_trace();
        run(120);
        chk("t3_post_inc",  64'(inc_cnt), 64'd0);
        chk("t3_post_done", 64'(done_cnt), 64'd0);
        chk("t3_post_busy", 64'(busy_cnt), 64'd0);
        chk("t3_post_tx0",  64'(tx0_cnt), 64'd0);

        // Start held high, then re-raised while busy: one playback only
        load(mk(1'b1, 1'b0, 5), mk(1'b0, 1'b0, 2), mk(1'b1, 1'b1, 0));
        restart_ptr();
        clear_trace();
        bus.start = 1'b1;
        run(10);
        bus.start = 1'b0;
        run(2);
        bus.start = 1'b1;
        run(2);
        bus.start = 1'b0;
        run(10);
        chk("t4_tx",   64'(tx_tr[23:0]),   64'hFFE3FF);
        chk("t4_inc",  64'(inc_cnt), 64'd2);
        chk("t4_done", 64'(done_cnt), 64'd1);
        chk("t4_busy", 64'(busy_tr[23:0]), 64'h007FFE);
        chk("t4_wcnt", 64'(bus.wordCountDBG), 64'd3);

        // Async reset mid-playback, then replay from the top
        load(mk(1'b0, 1'b0, 20), mk(1'b1, 1'b1, 0), 32'd0);
        restart_ptr();
        start_pulse_run(8);
        chk("t5_mid_tx", 64'(bus.txOut), 64'd0);
        resetN = 1'b0;
        #1;
        chk("t5_rst_tx",   64'(bus.txOut), 64'd1);
        chk("t5_rst_busy", 64'(bus.busy), 64'd0);
        chk("t5_rst_wcnt", 64'(bus.wordCountDBG), 64'd0);
        chk("t5_rst_inc",  64'(bus.incrementAddr), 64'd0);
        #2 resetN = 1'b1;
        start_pulse_run(20);
        chk("t5_tx",   64'(tx_tr[19:0]),   64'h0000F);
        chk("t5_inc",  64'(inc_tr[19:0]),  64'h00010);
        chk("t5_busy", 64'(busy_tr[19:0]), 64'hFFFFE);
        chk("t5_wcnt", 64'(bus.wordCountDBG), 64'd1);
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;

`ifdef SIG_PLAYBACK_LOOP_EN
        // Two-word table looped for three passes
        load(mk(1'b0, 1'b0, 3), mk(1'b1, 1'b1, 2), 32'd0);
        do_reset();
        bus.loopEn = 1'b1;
        start_pulse_run(34);
        chk("t6_tx",   64'(tx_tr[33:0]), 64'h3F0FC3F0F);
        chk("t6_rew",  64'(rew_cnt), 64'd3);
        chk("t6_done", 64'(done_cnt), 64'd0);
        chk("t6_inc",  64'(inc_cnt), 64'd3);
        chk("t6_wcnt", 64'(bus.wordCountDBG), 64'd6);
        chk("t6_undr", 64'(bus.underrun), 64'd0);
        bus.loopEn = 1'b0;
        bus.abort  = 1'b1;
        run(1);
        bus.abort  = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
